// File: rtl/riscv_finish_monitor.sv
// Simulation end-of-test monitor: catches the tohost store, records the pass/fail result and counts RUN cycles and retirements.
// Optional watchdog enabled by defining FINISH_MONITOR_TIMEOUT_EN.
module riscv_finish_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        finish_flag,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timeout,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_t      state, state_n;
  logic        finish_n, pass_n, timeout_n;
  logic [30:0] code_n;
  logic [31:0] cyc_n, ir_n;
  logic        finish_wr;

  // Only odd values written to tohost end the run; even values are ignored.
  assign finish_wr = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

`ifdef FINISH_MONITOR_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    finish_n  = finish_flag;
    pass_n    = pass;
    code_n    = fail_code;
    timeout_n = 1'b0;
    cyc_n     = cycle_count;
    ir_n      = instret_count;
    if (state != DONE) begin
      if (instr_valid && instret_count != CNT_MAX) ir_n = instret_count + 32'd1;
      if (state == RUN && cycle_count != CNT_MAX) cyc_n = cycle_count + 32'd1;
      if (state == IDLE && instr_valid) state_n = RUN;
      if (finish_wr) begin
        state_n  = DONE;
        finish_n = 1'b1;
        pass_n   = (mem_wdata == 32'd1);
        code_n   = mem_wdata[31:1];
      end
`ifdef FINISH_MONITOR_TIMEOUT_EN
      // A finish write in the same cycle takes priority over the watchdog.
      else if (state == RUN && cycle_count == TO_LAST) begin
        state_n   = DONE;
        finish_n  = 1'b1;
        pass_n    = 1'b0;
        code_n    = 31'h7FFF_FFFF;
        timeout_n = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      finish_flag   <= 1'b0;
      pass          <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      finish_flag   <= finish_n;
      pass          <= pass_n;
      fail_code     <= code_n;
      cycle_count   <= cyc_n;
      instret_count <= ir_n;
    end
  end

`ifdef FINISH_MONITOR_TIMEOUT_EN
  // timeout is sticky once set; DONE holds it because nothing clears it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)           timeout_q <= 1'b0;
    else if (timeout_n) timeout_q <= 1'b1;
  end
`endif

endmodule

// File: doc/riscv_finish_monitor.md
RISCV_FINISH_MONITOR -- requirements
Module: riscv_finish_monitor

Interface
REQ-001 The module SHALL provide parameter TOHOST_ADDR, default 32'h0000_1000, meaning the byte address whose store ends simulation.
REQ-002 The module SHALL provide parameter TIMEOUT_CYCLES, default 100000, meaning the maximum number of RUN cycles before a forced finish.
REQ-003 The module SHALL provide port clock, input, 1 bit, meaning the single system clock; all state updates on its rising edge.
REQ-004 The module SHALL provide port rst, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-005 The module SHALL provide port instr_valid, input, 1 bit, meaning one instruction retires this cycle.
REQ-006 The module SHALL provide port mem_we, input, 1 bit, meaning the CPU data-memory store strobe.
REQ-007 The module SHALL provide port mem_addr, input, 32 bits, meaning the store byte address.
REQ-008 The module SHALL provide port mem_wdata, input, 32 bits, meaning the store data.
REQ-009 The module SHALL provide port finish_flag, output, 1 bit, meaning the run is over; sticky until reset.
REQ-010 The module SHALL provide port pass, output, 1 bit, meaning the program reported success.
REQ-011 The module SHALL provide port fail_code, output, 31 bits, meaning the program-reported failure code.
REQ-012 The module SHALL provide port timeout, output, 1 bit, meaning the watchdog ended the run.
REQ-013 The module SHALL provide port cycle_count, output, 32 bits, meaning the number of clocks spent in RUN.
REQ-014 The module SHALL provide port instret_count, output, 32 bits, meaning the number of retired instructions.

Function
REQ-015 The module SHALL implement the FSM states IDLE, RUN and DONE; DONE is absorbing until reset.
REQ-016 The FSM SHALL go IDLE->RUN on the first cycle with instr_valid=1.
REQ-017 A finish write SHALL be mem_we=1 with mem_addr==TOHOST_ADDR and mem_wdata[0]=1.
REQ-018 A finish write SHALL be accepted in IDLE or RUN and SHALL move the FSM to DONE on that edge.
REQ-019 A store to TOHOST_ADDR with mem_wdata[0]=0 SHALL be ignored, with no state change.
REQ-020 On a finish write with mem_wdata==1, the module SHALL register pass=1 and fail_code=0.
REQ-021 On a finish write with any other value, the module SHALL register pass=0 and fail_code=mem_wdata[31:1].
REQ-022 All outputs SHALL be registered; finish_flag, pass, fail_code and timeout update on the same edge the FSM enters DONE, visible one cycle after the qualifying inputs.
REQ-023 cycle_count SHALL increment by 1 on every clock edge while in RUN, including the edge leaving RUN, and SHALL saturate at 32'hFFFF_FFFF.
REQ-024 instret_count SHALL increment on every edge with instr_valid=1 in IDLE or RUN, including the IDLE->RUN edge and a retirement coincident with a finish write, and SHALL saturate at 32'hFFFF_FFFF.
REQ-025 In DONE, all counters and result outputs SHALL be frozen, and instr_valid and mem_we SHALL be ignored.

Reset
REQ-026 On rst=0, asynchronously, the state SHALL be IDLE and finish_flag, pass, fail_code, timeout, cycle_count and instret_count SHALL all be 0.
REQ-027 Reset asserted in any state, including mid-RUN or DONE, SHALL discard all results; after rst=1, operation restarts from IDLE.

Configuration
REQ-028 With macro FINISH_MONITOR_TIMEOUT_EN defined, the watchdog SHALL be active, as follows:
- When in RUN, no finish write occurs and cycle_count==TIMEOUT_CYCLES-1, the FSM SHALL enter DONE on that edge.
- On that edge it SHALL set timeout=1, finish_flag=1, pass=0 and fail_code=31'h7FFF_FFFF.
- A finish write in the same cycle SHALL win, leaving timeout=0.
REQ-029 Without FINISH_MONITOR_TIMEOUT_EN, the module SHALL contain no watchdog comparator and timeout SHALL be constant 0.

Verification
REQ-030 The bench SHALL cover the pass path: reset, 10 cycles of instr_valid=1, then store 32'h1 to 32'h1000 -> next cycle finish_flag=1, pass=1, fail_code=0, instret_count=10, cycle_count=10.
REQ-031 The bench SHALL cover the fail path: store 32'h0000_0007 to 32'h1000 -> finish_flag=1, pass=0, fail_code=3.
REQ-032 The bench SHALL cover ignored stores:
- Store 32'h6 to 32'h1000 -> finish_flag stays 0.
- Store 32'h1 to 32'h1004 -> finish_flag stays 0.
- Both -> the FSM stays in RUN.
REQ-033 The bench SHALL cover the watchdog: with the macro defined and TIMEOUT_CYCLES=20, run with no finish write -> timeout=1, finish_flag=1 and cycle_count=20 after 20 RUN cycles; without the macro, timeout stays 0.
REQ-034 The bench SHALL cover reset mid-run: pull rst low for 1 ns at cycle 5 of RUN -> all outputs 0 immediately, then a fresh run counts from 0.
REQ-035 The bench SHALL cover DONE behaviour: after pass, apply 5 more instr_valid and a store of 32'h3 to 32'h1000 -> outputs unchanged.
